// File: rtl/dual_mem_param.sv
// Parametrised 2-write / 2-read RAM with byte enables, write-first bypass,
// selectable read latency and a post-reset clear sweep.
module dual_mem_param #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1,
    parameter int WR_PRIO    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we_1,
    input  logic [ADDR_W-1:0]   wr_addr1,
    input  logic [DATA_W-1:0]   data1,
    input  logic [DATA_W/8-1:0] be_1,
    input  logic                we_2,
    input  logic [ADDR_W-1:0]   wr_addr2,
    input  logic [DATA_W-1:0]   data2,
    input  logic [DATA_W/8-1:0] be_2,
    input  logic                re_1,
    input  logic [ADDR_W-1:0]   re_addr1,
    input  logic                re_2,
    input  logic [ADDR_W-1:0]   re_addr2,
    output logic [DATA_W-1:0]   read_out1,
    output logic                rvalid_1,
    output logic [DATA_W-1:0]   read_out2,
    output logic                rvalid_2,
    output logic                init_busy,
    output logic                wr_collision
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam state_t RST_ST = (INIT_CLEAR != 0) ? CLEAR : READY;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready;
    logic              wr1, wr2, rd1, rd2;
    logic              same_wa;
    logic [NB-1:0]     wm1, wm2;
    logic              coll_d, coll_q;
    logic [DATA_W-1:0] rd_word1, rd_word2;
    logic [DATA_W-1:0] out1_q, out2_q;
    logic              v1_q, v2_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: state_d = RST_ST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_ST;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign ready     = (state_q == READY);
    assign init_busy = !ready;
    assign wr1       = ready && we_1;
    assign wr2       = ready && we_2;
    assign rd1       = ready && re_1;
    assign rd2       = ready && re_2;
    assign same_wa   = (wr_addr1 == wr_addr2);

    // Overlapping bytes are granted to exactly one port, so masks stay disjoint
    always_comb begin
        wm1 = be_1 & {NB{wr1}};
        wm2 = be_2 & {NB{wr2}};
        if (same_wa) begin
            if (WR_PRIO == 2) begin
                wm1 = wm1 & ~wm2;
            end else begin
                wm2 = wm2 & ~wm1;
            end
        end
    end

    assign coll_d = wr1 && wr2 && same_wa && (|(be_1 & be_2));

    always_ff @(posedge clk) begin
        if (!ready) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wm1[i]) begin
                    mem_q[wr_addr1][8*i +: 8] <= data1[8*i +: 8];
                end
                if (wm2[i]) begin
                    mem_q[wr_addr2][8*i +: 8] <= data2[8*i +: 8];
                end
            end
        end
    end

    // Write-first bypass: overlay this edge's write bytes on the stored word
    always_comb begin
        rd_word1 = mem_q[re_addr1];
        rd_word2 = mem_q[re_addr2];
        for (int i = 0; i < NB; i++) begin
            if (wm1[i] && (wr_addr1 == re_addr1)) begin
                rd_word1[8*i +: 8] = data1[8*i +: 8];
            end
            if (wm2[i] && (wr_addr2 == re_addr1)) begin
                rd_word1[8*i +: 8] = data2[8*i +: 8];
            end
            if (wm1[i] && (wr_addr1 == re_addr2)) begin
                rd_word2[8*i +: 8] = data1[8*i +: 8];
            end
            if (wm2[i] && (wr_addr2 == re_addr2)) begin
                rd_word2[8*i +: 8] = data2[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s1v_q, s2v_q;
        logic [DATA_W-1:0] s1d_q, s2d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1v_q  <= 1'b0;
                s2v_q  <= 1'b0;
                s1d_q  <= '0;
                s2d_q  <= '0;
                v1_q   <= 1'b0;
                v2_q   <= 1'b0;
                out1_q <= '0;
                out2_q <= '0;
            end else begin
                s1v_q <= rd1;
                s2v_q <= rd2;
                if (rd1) begin
                    s1d_q <= rd_word1;
                end
                if (rd2) begin
                    s2d_q <= rd_word2;
                end
                v1_q <= s1v_q;
                v2_q <= s2v_q;
                if (s1v_q) begin
                    out1_q <= s1d_q;
                end
                if (s2v_q) begin
                    out2_q <= s2d_q;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q   <= 1'b0;
                v2_q   <= 1'b0;
                out1_q <= '0;
                out2_q <= '0;
            end else begin
                v1_q <= rd1;
                v2_q <= rd2;
                if (rd1) begin
                    out1_q <= rd_word1;
                end
                if (rd2) begin
                    out2_q <= rd_word2;
                end
            end
        end
    end

    assign read_out1    = out1_q;
    assign read_out2    = out2_q;
    assign rvalid_1     = v1_q;
    assign rvalid_2     = v2_q;
    assign wr_collision = coll_q;

endmodule
